// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and saturation helpers.
package fixed_point_pkg;
  localparam int DEF_N    = 32;
  localparam int DEF_FRAC = 16;
  localparam int MAX_W    = 128;

  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO} sat_e;

  // Largest representable value for an n-bit result.
  function automatic logic [MAX_W-1:0] sat_hi(input int n, input bit s);
    return s ? ((MAX_W'(1) << (n - 1)) - MAX_W'(1)) : ((MAX_W'(1) << n) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] sat_lo(input int n, input bit s);
    return s ? (MAX_W'(1) << (n - 1)) : '0;
  endfunction

  function automatic sat_e sat_classify(input logic in_range, input logic neg);
    if (in_range) return SAT_NONE;
    return neg ? SAT_LO : SAT_HI;
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One-entry valid/ready register slice; refills in the same cycle it drains.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end
endmodule

// File: rtl/product_normalize.sv
// Rounds, shifts and saturates a 2N-bit multiplier product to N bits in two stages.
module product_normalize
  import fixed_point_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int FRAC   = DEF_FRAC,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_sat,
  output logic [15:0]    sat_count,
  input  logic           clr_count
);
  localparam int W = 2*N + 1;
  localparam logic [W-1:0] RND  = (FRAC == 0) ? '0 : (W'(1) << ((FRAC == 0) ? 0 : FRAC - 1));
  localparam logic [N-1:0] HI_V = N'(sat_hi(N, SIGNED != 0));
  localparam logic [N-1:0] LO_V = N'(sat_lo(N, SIGNED != 0));

  logic [W-1:0] ext, sum, r_d, r_q;
  logic         s1_valid, s2_ready, in_range, neg;
  sat_e         kind;
  logic [N:0]   res_d, res_q;
  logic [15:0]  cnt_d, cnt_q;

  // One extra bit keeps the rounding add from overflowing in either signedness.
  always_comb begin
    ext = (SIGNED != 0) ? {in_product[2*N-1], in_product} : {1'b0, in_product};
    sum = ext + RND;
    r_d = (SIGNED != 0) ? W'($signed(sum) >>> FRAC) : (sum >> FRAC);
  end

  pipe_stage #(.W(W)) u_s1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(r_d),
    .out_valid_o(s1_valid), .out_ready_i(s2_ready), .out_data_o(r_q)
  );

  always_comb begin
    neg      = (SIGNED != 0) && r_q[W-1];
    in_range = (SIGNED != 0) ? ((&r_q[W-1:N-1]) || !(|r_q[W-1:N-1])) : !(|r_q[W-1:N]);
    kind     = sat_classify(in_range, neg);
    case (kind)
      SAT_HI:  res_d = {1'b1, HI_V};
      SAT_LO:  res_d = {1'b1, LO_V};
      default: res_d = {1'b0, r_q[N-1:0]};
    endcase
  end

  pipe_stage #(.W(N+1)) u_s2 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(s1_valid), .in_ready_o(s2_ready), .in_data_i(res_d),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(res_q)
  );

  assign out_sat   = res_q[N];
  assign out_data  = res_q[N-1:0];
  assign sat_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) cnt_d = '0;
    else if (out_valid && out_ready && out_sat && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
